// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the branch predictor.
// BTB entries carry tag/target at the full package address width; narrower PCs zero-extend.
package bp_pkg;

    localparam int unsigned BP_ADDR_WIDTH = 32;

    typedef struct packed {
        logic                     valid;
        logic [BP_ADDR_WIDTH-1:0] tag;
        logic [BP_ADDR_WIDTH-1:0] target;
        logic                     isJump;
    } btb_entry_t;

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

    // Weakly not-taken: 2^(w-1)-1
    function automatic int unsigned ctr_reset(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Bimodal table of saturating counters: combinational read of the MSB, synchronous
// increment/decrement on update.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned CTR_WIDTH = 2,
    localparam int unsigned IDX_W    = idx_width(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken_c,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_reset(CTR_WIDTH));

    logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_d [ENTRIES];
    logic [CTR_WIDTH-1:0] upd_cur;

    assign rd_taken_c = ctr_q[rd_idx][CTR_WIDTH-1];

    always_comb begin
        ctr_d   = ctr_q;
        upd_cur = ctr_q[upd_idx];
        if (upd_en) begin
            if (upd_taken && (upd_cur != CTR_MAX)) begin
                ctr_d[upd_idx] = upd_cur + CTR_WIDTH'(1);
            end else if (!upd_taken && (upd_cur != CTR_MIN)) begin
                ctr_d[upd_idx] = upd_cur - CTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + bimodal predictor with zero-latency fetch lookup and execute-stage
// mispredict detection. Define BRANCH_PREDICTOR_PERF_EN to add branch/mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = BP_ADDR_WIDTH,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CTR_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pcF,
    output logic                  predTakenF,
    output logic [ADDR_WIDTH-1:0] predNextPCF,
    input  logic                  updValid,
    input  logic                  updIsBranch,
    input  logic [ADDR_WIDTH-1:0] updPC,
    input  logic                  updTaken,
    input  logic [ADDR_WIDTH-1:0] updTarget,
    input  logic                  updPredTaken,
    input  logic [ADDR_WIDTH-1:0] updPredTarget,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] recoverPC
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    output logic [31:0]           perfBranches,
    output logic [31:0]           perfMispredicts
`endif
);

    localparam int unsigned BHT_IDX_W = idx_width(BHT_ENTRIES);
    localparam int unsigned BTB_IDX_W = idx_width(BTB_ENTRIES);
    localparam int unsigned TAG_W     = tag_width(ADDR_WIDTH, BTB_ENTRIES);

    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t btb_d [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] f_btb_idx;
    logic [BHT_IDX_W-1:0] f_bht_idx;
    logic [TAG_W-1:0]     f_tag;
    btb_entry_t           f_entry;
    logic                 f_hit;
    logic                 f_ctr_taken;

    logic [BTB_IDX_W-1:0] u_btb_idx;
    logic [BHT_IDX_W-1:0] u_bht_idx;
    logic [TAG_W-1:0]     u_tag;

    assign f_btb_idx = pcF[BTB_IDX_W+1:2];
    assign f_bht_idx = pcF[BHT_IDX_W+1:2];
    assign f_tag     = pcF[ADDR_WIDTH-1:BTB_IDX_W+2];
    assign u_btb_idx = updPC[BTB_IDX_W+1:2];
    assign u_bht_idx = updPC[BHT_IDX_W+1:2];
    assign u_tag     = updPC[ADDR_WIDTH-1:BTB_IDX_W+2];

    // Only conditional branches train the counters; JAL leaves them alone.
    bp_sat_counter_table #(
        .ENTRIES   (BHT_ENTRIES),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst),
        .rd_idx     (f_bht_idx),
        .rd_taken_c (f_ctr_taken),
        .upd_en     (updValid && updIsBranch),
        .upd_idx    (u_bht_idx),
        .upd_taken  (updTaken)
    );

    // Fetch lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        f_entry     = btb_q[f_btb_idx];
        f_hit       = f_entry.valid && (f_entry.tag == BP_ADDR_WIDTH'(f_tag));
        predTakenF  = f_hit && (f_entry.isJump || f_ctr_taken);
        predNextPCF = pcF + ADDR_WIDTH'(4);
        if (predTakenF) begin
            predNextPCF = ADDR_WIDTH'(f_entry.target);
        end
    end

    // Taken outcomes allocate unconditionally, evicting any aliased entry.
    always_comb begin
        btb_d = btb_q;
        if (updValid && updTaken) begin
            btb_d[u_btb_idx].valid  = 1'b1;
            btb_d[u_btb_idx].tag    = BP_ADDR_WIDTH'(u_tag);
            btb_d[u_btb_idx].target = BP_ADDR_WIDTH'(updTarget);
            btb_d[u_btb_idx].isJump = !updIsBranch;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

    always_comb begin
        mispredict = 1'b0;
        recoverPC  = '0;
        if (updValid) begin
            mispredict = (updTaken != updPredTaken) ||
                         (updTaken && (updTarget != updPredTarget));
            recoverPC  = updTaken ? updTarget : (updPC + ADDR_WIDTH'(4));
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_branches_d;
    logic [31:0] perf_mispredicts_q;
    logic [31:0] perf_mispredicts_d;

    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (updValid) begin
            perf_branches_d = perf_branches_q + 32'd1;
        end
        if (mispredict) begin
            perf_mispredicts_d = perf_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perfBranches    = perf_branches_q;
    assign perfMispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then randomized traffic,
// checked against an array-based reference model of the prediction rules.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predNextPCF;
    logic        updValid;
    logic        updIsBranch;
    logic [31:0] updPC;
    logic        updTaken;
    logic [31:0] updTarget;
    logic        updPredTaken;
    logic [31:0] updPredTarget;
    logic        mispredict;
    logic [31:0] recoverPC;
`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] perfBranches;
    logic [31:0] perfMispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pcF           (pcF),
        .predTakenF    (predTakenF),
        .predNextPCF   (predNextPCF),
        .updValid      (updValid),
        .updIsBranch   (updIsBranch),
        .updPC         (updPC),
        .updTaken      (updTaken),
        .updTarget     (updTarget),
        .updPredTaken  (updPredTaken),
        .updPredTarget (updPredTarget),
        .mispredict    (mispredict),
        .recoverPC     (recoverPC)
`ifdef BRANCH_PREDICTOR_PERF_EN
        ,
        .perfBranches    (perfBranches),
        .perfMispredicts (perfMispredicts)
`endif
    );

    typedef struct {
        bit [31:0]   pc;
        bit          ptk;
        bit [31:0]   pnext;
        bit          mp;
        bit [31:0]   rpc;
        int unsigned pb;
        int unsigned pm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: BTB keyed by word address, counters as plain integers 0..3.
    bit          m_v   [16];
    bit          m_j   [16];
    bit [31:0]   m_pc  [16];
    bit [31:0]   m_tgt [16];
    int          m_ctr [64];
    int unsigned m_pb;
    int unsigned m_pm;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_j[i] = 0; m_pc[i] = 0; m_tgt[i] = 0;
        end
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_pb = 0;
        m_pm = 0;
    endfunction

    function automatic void m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] nxt);
        int b;
        bit hit;
        b   = int'((pc >> 2) % 16);
        hit = m_v[b] && ((m_pc[b] >> 6) == (pc >> 6));
        tk  = hit && (m_j[b] || m_ctr[int'((pc >> 2) % 64)] >= 2);
        nxt = tk ? m_tgt[b] : pc + 32'd4;
    endfunction

    task automatic chk(input string name, input bit [31:0] pc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pcF=%h: got %h expected %h", name, pc, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a lookup and an update response.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("predTakenF", e.pc, {31'd0, predTakenF}, {31'd0, e.ptk});
            chk("predNextPCF", e.pc, predNextPCF, e.pnext);
            chk("mispredict", e.pc, {31'd0, mispredict}, {31'd0, e.mp});
            chk("recoverPC", e.pc, recoverPC, e.rpc);
`ifdef BRANCH_PREDICTOR_PERF_EN
            chk("perfBranches", e.pc, perfBranches, e.pb);
            chk("perfMispredicts", e.pc, perfMispredicts, e.pm);
`endif
        end
    end

    task automatic issue(input bit [31:0] pc, input bit v, input bit isb, input bit [31:0] upc,
                         input bit tk, input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
        exp_t e;
        int b;
        int c;
        @(posedge clk);
        #1;
        pcF = pc; updValid = v; updIsBranch = isb; updPC = upc;
        updTaken = tk; updTarget = tgt; updPredTaken = ptk; updPredTarget = ptgt;
        e.pc = pc;
        m_predict(pc, e.ptk, e.pnext);
        e.mp  = v && ((tk != ptk) || (tk && tgt != ptgt));
        e.rpc = !v ? 32'd0 : (tk ? tgt : upc + 32'd4);
        e.pb  = m_pb;
        e.pm  = m_pm;
        q.push_back(e);
        if (v) begin
            m_pb++;
            if (e.mp) m_pm++;
            c = int'((upc >> 2) % 64);
            if (isb) m_ctr[c] = tk ? ((m_ctr[c] < 3) ? m_ctr[c] + 1 : 3)
                                   : ((m_ctr[c] > 0) ? m_ctr[c] - 1 : 0);
            if (tk) begin
                b = int'((upc >> 2) % 16);
                m_v[b] = 1; m_pc[b] = upc; m_tgt[b] = tgt; m_j[b] = !isb;
            end
        end
    endtask

    task automatic look(input bit [31:0] pc);
        issue(pc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    function automatic bit [31:0] rand_pc();
        if ($urandom_range(7) == 0) return $urandom & 32'hFFFF_FFFC;
        return 32'($urandom_range(127)) << 2;
    endfunction

    initial begin
        bit [31:0] upc;
        bit [31:0] ptgt;
        bit        ptk;
        bit        isb;
        bit        tk;
        rst = 1'b0;
        pcF = 0; updValid = 0; updIsBranch = 0; updPC = 0; updTaken = 0;
        updTarget = 0; updPredTaken = 0; updPredTarget = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Cold start and wrap of PC+4
        look(32'h100);
        look(32'hFFFF_FFFC);

        // First taken branch trains both tables
        issue(32'h20, 1, 1, 32'h20, 1, 32'h08, 0, 32'h24);
        look(32'h20);

        // Hysteresis
        repeat (3) issue(32'h20, 1, 1, 32'h20, 1, 32'h08, 1, 32'h08);
        issue(32'h20, 1, 1, 32'h20, 0, 32'h08, 1, 32'h08);
        look(32'h20);
        issue(32'h20, 1, 1, 32'h20, 0, 32'h08, 1, 32'h08);
        look(32'h20);

        // JAL
        issue(32'h40, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
        issue(32'h40, 1, 0, 32'h40, 1, 32'h80, 1, 32'h80);
        look(32'h40);

        // Aliasing, and lookup in the same cycle as the first update
        issue(32'h20, 1, 1, 32'h20, 1, 32'h08, 0, 32'h24);
        issue(32'h60, 1, 1, 32'h60, 1, 32'h90, 0, 32'h64);
        look(32'h20);
        look(32'h60);
        drain();

        // Reset asserted while an update is being presented
        @(posedge clk);
        #1;
        pcF = 32'h60; updValid = 1; updIsBranch = 1; updPC = 32'h100; updTaken = 1;
        updTarget = 32'h200; updPredTaken = 0; updPredTarget = 32'h104;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        updValid = 0;
        m_reset();
        look(32'h20);
        look(32'h40);
        look(32'h60);
        look(32'h100);

        // Five updates, two of them mispredicted
        issue(32'h0, 1, 1, 32'h10, 0, 32'h0, 0, 32'h0);
        issue(32'h0, 1, 1, 32'h14, 1, 32'h30, 0, 32'h18);
        issue(32'h0, 1, 1, 32'h14, 1, 32'h30, 1, 32'h30);
        issue(32'h0, 1, 0, 32'h50, 1, 32'h70, 0, 32'h54);
        issue(32'h0, 1, 1, 32'h10, 0, 32'h0, 0, 32'h0);
        look(32'h14);
        look(32'h50);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            upc = rand_pc();
            isb = ($urandom_range(3) != 0);
            tk  = isb ? 1'($urandom_range(1)) : 1'b1;
            if ($urandom_range(1) == 0) begin
                m_predict(upc, ptk, ptgt);
            end else begin
                ptk  = 1'($urandom_range(1));
                ptgt = (ptk != 0) ? ($urandom & 32'hFFFF_FFFC) : upc + 32'd4;
            end
            issue(rand_pc(), 1'($urandom_range(3) != 0), isb, upc, tk,
                  32'($urandom_range(127)) << 2, ptk, ptgt);
        end
        look(32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
